// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART link (rx and tx sides).
// Holds the FSM state encoding, oversampling constants and frame defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE      = 16;
    localparam int MID_TICK        = 7;
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

    // Data enters at bit 7 and shifts right, so a short frame sits in the top bits.
    function automatic logic [7:0] align_data(input logic [7:0] shreg, input int dbit);
        return shreg >> (8 - dbit);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs.
// RESET_VAL sets the value both stages take during reset.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    // next values for the two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // synchronizer stages
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start bit, DBIT data bits LSB first, no parity.
// Produces a registered byte, a one-cycle done strobe and a framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err
);

    localparam logic [4:0] MID_S       = 5'(MID_TICK);
    localparam logic [4:0] DATA_LAST_S = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST_S = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

    logic        rx_s;
    uart_state_e state_q, state_d;
    logic [4:0]  s_q, s_d;
    logic [2:0]  n_q, n_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  dout_q, dout_d;
    logic        rx_done_q, rx_done_d;
    logic        frame_err_q, frame_err_d;
    logic        stop_done_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign stop_done_s = (state_q == ST_STOP) && s_tick && (s_q == STOP_LAST_S);

    // state, counter, shift-register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= 5'd0;
            n_q         <= 3'd0;
            b_q         <= 8'd0;
            dout_q      <= 8'd0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // next-state and datapath
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                // Falling edge is taken without waiting for a tick.
                if (!rx_s) begin
                    state_d = ST_START;
                    s_d     = 5'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (s_tick && (s_q == MID_S)) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        s_d     = 5'd0;
                        n_d     = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (s_tick) begin
                    s_d = s_q + 5'd1;
                end else begin
                    s_d = s_q;
                end
            end
            ST_DATA: begin
                if (s_tick && (s_q == DATA_LAST_S)) begin
                    s_d = 5'd0;
                    b_d = {rx_s, b_q[7:1]};
                    if (n_q == N_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        n_d = n_q + 3'd1;
                    end
                end else if (s_tick) begin
                    s_d = s_q + 5'd1;
                end else begin
                    s_d = s_q;
                end
            end
            ST_STOP: begin
                if (stop_done_s) begin
                    state_d = ST_IDLE;
                end else if (s_tick) begin
                    s_d = s_q + 5'd1;
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // output register loads at the end of the stop period
    always_comb begin
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;
        if (stop_done_s) begin
            dout_d      = align_data(b_q, DBIT);
            frame_err_d = ~rx_s;
            rx_done_d   = 1'b1;
        end else begin
            rx_done_d   = 1'b0;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = rx_done_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected frames popped on each done strobe.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx2;
    logic       s_tick;
    logic [7:0] dout;
    logic [7:0] dout2;
    logic       done;
    logic       done2;
    logic       ferr;
    logic       ferr2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    int last_done_cyc = 0;
    int last_done2_cyc = 0;
    int start_cyc = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp2_q[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) u_dut (
        .clk(clk), .rst(rst), .rx(rx), .s_tick(s_tick),
        .dout(dout), .rx_done_tick(done), .frame_err(ferr)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) u_dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .s_tick(s_tick),
        .dout(dout2), .rx_done_tick(done2), .frame_err(ferr2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // tick generator, cycle counter and scoreboard monitors, all on the falling edge
    initial begin
        int div;
        logic [8:0] e;
        div = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            s_tick = (div == 3) ? 1'b1 : 1'b0;
            div = (div + 1) % 4;
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) check_eq("unexpected_strobe", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check_eq("dout", 32'(dout), 32'(e[7:0]));
                    check_eq("frame_err", 32'(ferr), 32'(e[8]));
                end
            end
            if (done2 === 1'b1) begin
                done2_cnt++;
                last_done2_cyc = cyc;
                if (exp2_q.size() == 0) check_eq("unexpected_strobe2", 32'd1, 32'd0);
                else begin
                    e = exp2_q.pop_front();
                    check_eq("dout2", 32'(dout2), 32'(e[7:0]));
                    check_eq("frame_err2", 32'(ferr2), 32'(e[8]));
                end
            end
        end
    end

    task automatic drive(input logic v, input bit use2);
        if (use2) rx2 = v;
        else rx = v;
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input int stop_clk,
                              input logic stop_val, input bit use2);
        drive(1'b0, use2);
        start_cyc = cyc;
        idle_clk(BIT_CLK);
        for (int i = 0; i < nbits; i++) begin
            drive(data[i], use2);
            idle_clk(BIT_CLK);
        end
        drive(stop_val, use2);
        idle_clk(stop_clk);
        drive(1'b1, use2);
    endtask

    task automatic wait_done(input bit use2, input int target, input string tag);
        int n;
        n = 0;
        while (((use2 ? done2_cnt : done_cnt) < target) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'((use2 ? done2_cnt : done_cnt) >= target), 32'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        rx  = 1'b1;
        rx2 = 1'b1;
        idle_clk(3);
        rst = 1'b0;
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ferr", 32'(ferr), 32'd0);
        check_eq("rst_dout2", 32'(dout2), 32'd0);
        check_eq("rst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
        idle_clk(20);

        // nominal frame and its latency
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 8, BIT_CLK, 1'b1, 1'b0);
        wait_done(1'b0, 1, "nominal_done");
        lat = last_done_cyc - start_cyc;
        check_eq("nominal_latency", 32'((lat >= 600) && (lat <= 620)), 32'd1);
        idle_clk(128);
        check_eq("nominal_single", 32'(done_cnt), 32'd1);

        // false start: 20 clk low is only 5 ticks
        drive(1'b0, 1'b0);
        idle_clk(20);
        drive(1'b1, 1'b0);
        idle_clk(200);
        check_eq("false_start_cnt", 32'(done_cnt), 32'd1);
        check_eq("false_start_dout", 32'(dout), 32'hA5);
        check_eq("false_start_state", 32'(u_dut.state_q), 32'(ST_IDLE));

        // framing error, then a clean frame
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 8, 48, 1'b0, 1'b0);
        idle_clk(256);
        wait_done(1'b0, 2, "ferr_done");
        check_eq("ferr_no_extra", 32'(done_cnt), 32'd2);
        check_eq("ferr_recover_state", 32'(u_dut.state_q), 32'(ST_IDLE));
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 8, BIT_CLK, 1'b1, 1'b0);
        wait_done(1'b0, 3, "after_ferr_done");
        idle_clk(64);

        // back-to-back frames with no idle gap
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h00, 8, BIT_CLK, 1'b1, 1'b0);
        send_frame(8'hFF, 8, BIT_CLK, 1'b1, 1'b0);
        send_frame(8'h55, 8, BIT_CLK, 1'b1, 1'b0);
        wait_done(1'b0, 6, "b2b_done");
        idle_clk(128);
        check_eq("b2b_cnt", 32'(done_cnt), 32'd6);

        // reset in the middle of the 4th data bit of 0x12
        drive(1'b0, 1'b0);
        idle_clk(BIT_CLK);
        drive(1'b0, 1'b0);
        idle_clk(BIT_CLK);
        drive(1'b1, 1'b0);
        idle_clk(BIT_CLK);
        drive(1'b0, 1'b0);
        idle_clk(BIT_CLK);
        drive(1'b0, 1'b0);
        idle_clk(BIT_CLK / 2);
        rst = 1'b1;
        drive(1'b1, 1'b0);
        idle_clk(1);
        rst = 1'b0;
        check_eq("midrst_dout", 32'(dout), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_ferr", 32'(ferr), 32'd0);
        check_eq("midrst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
        idle_clk(640);
        check_eq("midrst_no_strobe", 32'(done_cnt), 32'd6);
        exp_q.push_back({1'b0, 8'h34});
        send_frame(8'h34, 8, BIT_CLK, 1'b1, 1'b0);
        wait_done(1'b0, 7, "midrst_next_done");
        idle_clk(64);

        // DBIT=7, two stop bits
        exp2_q.push_back({1'b0, 8'h7F});
        send_frame(8'h7F, 7, 2 * BIT_CLK, 1'b1, 1'b1);
        wait_done(1'b1, 1, "sweep_done");
        lat = last_done2_cyc - start_cyc;
        check_eq("sweep_latency", 32'((lat >= 600) && (lat <= 620)), 32'd1);
        idle_clk(128);
        check_eq("sweep_single", 32'(done2_cnt), 32'd1);

        check_eq("final_cnt", 32'(done_cnt), 32'd7);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("queue2_empty", 32'(exp2_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
